// File: rtl/shield_pkg.sv
// Shared types and constants for the shield datapath slaves.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shield_pkg;

  // Write-slave control states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2,
    ST_RESP    = 2'd3
  } shield_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/shield_counter.sv
// Loadable up/down counter; wraps naturally at its width.
// Latency: 1 cycle from load/incr/decr to cnt.
// Backpressure: none; load has priority, simultaneous incr+decr holds.
// Ports: clk, rst (sync, active-high), load/load_val, incr, decr, cnt.
module shield_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         incr,
  input  logic         decr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (incr && !decr) begin
      cnt <= cnt + W'(1);
    end else if (decr && !incr) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/shield_demuxp.sv
// Writes one data slice and its strobe slice into slot sel of a line register.
// Latency: 1 cycle from en to line/line_strb.
// Backpressure: none; clr wins over en, registers hold otherwise.
// Ports: clk, rst (sync, active-high), clr, en, sel, dat, strb, line, line_strb.
module shield_demuxp #(
  parameter int SLICE_W = 64,
  parameter int N       = 8,
  parameter int SEL_W   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic [SEL_W-1:0]         sel,
  input  logic [SLICE_W-1:0]       dat,
  input  logic [SLICE_W/8-1:0]     strb,
  output logic [SLICE_W*N-1:0]     line,
  output logic [SLICE_W*N/8-1:0]   line_strb
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      line      <= '0;
      line_strb <= '0;
    end else if (en) begin
      for (int k = 0; k < N; k++) begin
        if (sel == SEL_W'(k)) begin
          line[k*SLICE_W +: SLICE_W]           <= dat;
          line_strb[k*(SLICE_W/8) +: SLICE_W/8] <= strb;
        end
      end
    end
  end

endmodule

// File: rtl/shield_enreg.sv
// Enabled register with synchronous clear.
// Latency: 1 cycle from en to q.
// Backpressure: none; q holds while en is low.
// Ports: clk, rst (sync, active-high), en, d, q.
module shield_enreg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/shield_write_slv.sv
// Packs AXI W beats into a cache line with byte strobes, emits it, then B response on last line.
// Latency: cmd -> wready 1 cycle; final beat -> line_val 1 cycle; line hs -> bvalid/cmd_rdy 1 cycle.
// Backpressure: line_rdy low holds EMIT (outputs stable, wready=0); bready low holds RESP.
// Optional: SHIELD_WRITE_SLV_WLAST_CHECK_EN checks wlast against beat count, flagging SLVERR.
// Ports: clk, rst | cmd_* + burst_* | s_axi_w* | s_axi_b* | cache_line*, line_last, line_val/rdy | busy.
module shield_write_slv
  import shield_pkg::*;
#(
  parameter int CL_ID_WIDTH         = 6,
  parameter int CL_DATA_WIDTH       = 64,
  parameter int LINE_WIDTH          = 512,
  parameter int OFFSET_WIDTH        = 6,
  parameter int BURSTS_PER_LINE     = 8,
  parameter int BURSTS_PER_LINE_LOG = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 burst_count,
  input  logic [OFFSET_WIDTH-1:0]    burst_start_offset,
  input  logic                       burst_last,
  input  logic                       cmd_val,
  output logic                       cmd_rdy,
  input  logic [CL_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [CL_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                       s_axi_wlast,
  input  logic                       s_axi_wvalid,
  output logic                       s_axi_wready,
  output logic [CL_ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]                 s_axi_bresp,
  output logic                       s_axi_bvalid,
  input  logic                       s_axi_bready,
  output logic [LINE_WIDTH-1:0]      cache_line,
  output logic [LINE_WIDTH/8-1:0]    cache_line_strb,
  output logic                       line_last,
  output logic                       line_val,
  input  logic                       line_rdy,
  output logic                       busy
);

  shield_state_t                  state_q, state_d;
  logic [BURSTS_PER_LINE_LOG-1:0] idx;
  logic [7:0]                     rem;
  logic                           last_r;
  logic                           err_r;
  logic                           cmd_acc, w_hs, b_hs;

  // Handshakes are qualified by state directly so no ready output feeds back.
  assign cmd_acc = cmd_val      && (state_q == ST_IDLE);
  assign w_hs    = s_axi_wvalid && (state_q == ST_COLLECT);
  assign b_hs    = s_axi_bready && (state_q == ST_RESP);

  // Start slot comes from the top bits of the byte offset.
  shield_counter #(.W(BURSTS_PER_LINE_LOG)) u_idx (
    .clk      (clk),
    .rst      (rst),
    .load     (cmd_acc),
    .load_val (burst_start_offset[OFFSET_WIDTH-1 -: BURSTS_PER_LINE_LOG]),
    .incr     (w_hs),
    .decr     (1'b0),
    .cnt      (idx)
  );

  shield_counter #(.W(8)) u_rem (
    .clk      (clk),
    .rst      (rst),
    .load     (cmd_acc),
    .load_val (burst_count),
    .incr     (1'b0),
    .decr     (w_hs),
    .cnt      (rem)
  );

  shield_enreg #(.W(1)) u_last (
    .clk (clk),
    .rst (rst),
    .en  (cmd_acc),
    .d   (burst_last),
    .q   (last_r)
  );

  // Line buffer is cleared on command accept so unwritten slots read as 0.
  shield_demuxp #(
    .SLICE_W (CL_DATA_WIDTH),
    .N       (BURSTS_PER_LINE),
    .SEL_W   (BURSTS_PER_LINE_LOG)
  ) u_demux (
    .clk       (clk),
    .rst       (rst),
    .clr       (cmd_acc),
    .en        (w_hs),
    .sel       (idx),
    .dat       (s_axi_wdata),
    .strb      (s_axi_wstrb),
    .line      (cache_line),
    .line_strb (cache_line_strb)
  );

`ifdef SHIELD_WRITE_SLV_WLAST_CHECK_EN
  // Sticky across all lines of one request; only the B handshake clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (b_hs) begin
      err_r <= 1'b0;
    end else if (w_hs && (s_axi_wlast != (last_r && (rem == 8'd1)))) begin
      err_r <= 1'b1;
    end
  end
`else
  assign err_r = 1'b0;
  logic unused_wlast;
  assign unused_wlast = s_axi_wlast;
`endif

  logic unused_offset_lsbs;
  assign unused_offset_lsbs = ^burst_start_offset[OFFSET_WIDTH-BURSTS_PER_LINE_LOG-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_rdy      = 1'b0;
    s_axi_wready = 1'b0;
    line_val     = 1'b0;
    s_axi_bvalid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_rdy = 1'b1;
        if (cmd_val) begin
          // A zero-beat line goes straight out with an all-zero strobe.
          state_d = (burst_count == 8'd0) ? ST_EMIT : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid && (rem == 8'd1)) begin
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        line_val = 1'b1;
        if (line_rdy) begin
          state_d = last_r ? ST_RESP : ST_IDLE;
        end
      end
      ST_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign s_axi_bresp = ((state_q == ST_RESP) && err_r) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign s_axi_bid   = '0;
  assign line_last   = last_r;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: doc/shield_write_slv.md
# shield_write_slv

Write-direction slave for the shield datapath. Accepts AXI W beats from the CL and packs them into a `LINE_WIDTH` cache line with a per-byte strobe mask. Hands each assembled line to the datapath and issues the AXI B response once the final line of a request has been accepted. It is the counterpart of the shield read slave, which unpacks lines into R beats.

## Interface
Parameters:
- `CL_ID_WIDTH`, 6: AXI ID width.
- `CL_DATA_WIDTH`, 64: W beat data width in bits.
- `LINE_WIDTH`, 512: cache line width in bits.
- `OFFSET_WIDTH`, 6: byte-offset width within a line.
- `BURSTS_PER_LINE`, 8: equals `LINE_WIDTH/CL_DATA_WIDTH`.
- `BURSTS_PER_LINE_LOG`, 3: `log2(BURSTS_PER_LINE)`.

Ports:
- `clk`  in  1: the single clock.
- `rst`  in  1: synchronous, active-high reset.
- `burst_count`  in  8: number of W beats that land in this line.
- `burst_start_offset`  in  `OFFSET_WIDTH`: byte offset of the first beat.
- `burst_last`  in  1: this line is the last line of the AXI request.
- `cmd_val` / `cmd_rdy`  in / out  1: command handshake.
- `s_axi_wdata`  in  `CL_DATA_WIDTH`: W beat data.
- `s_axi_wstrb`  in  `CL_DATA_WIDTH/8`: W beat byte strobes.
- `s_axi_wlast`  in  1: W last-beat flag.
- `s_axi_wvalid` / `s_axi_wready`  in / out  1: W handshake.
- `s_axi_bid`  out  `CL_ID_WIDTH`: constant 0.
- `s_axi_bresp`  out  2: write response.
- `s_axi_bvalid` / `s_axi_bready`  out / in  1: B handshake.
- `cache_line`  out  `LINE_WIDTH`: assembled line.
- `cache_line_strb`  out  `LINE_WIDTH/8`: byte strobe mask for the line.
- `line_last`  out  1: registered copy of `burst_last`.
- `line_val` / `line_rdy`  out / in  1: line handshake to the datapath.
- `busy`  out  1: state is not IDLE.

## Operation
States are IDLE, COLLECT, EMIT and RESP.
- **IDLE**
  - `cmd_rdy`=1.
  - On `cmd_val`: load `idx` = `burst_start_offset[OFFSET_WIDTH-1 -: BURSTS_PER_LINE_LOG]`, `rem` = `burst_count`, `last_r` = `burst_last`.
  - Clear the line buffer and strobe mask to 0.
  - Go to COLLECT, or straight to EMIT if `burst_count`==0 (the line is emitted with an all-zero strobe).
- **COLLECT**
  - `s_axi_wready`=1.
  - On each W handshake: write data into slot `idx`, write strobes into strobe slot `idx`, `idx`++ (wraps modulo `BURSTS_PER_LINE`, so an overrun overwrites slot 0), `rem`--.
  - When the handshake occurs with `rem`==1, go to EMIT.
- **EMIT**
  - `line_val`=1.
  - `cache_line`, `cache_line_strb` and `line_last` hold stable until `line_rdy`.
  - On the handshake: go to RESP if `last_r`, else go to IDLE.
- **RESP**
  - `s_axi_bvalid`=1 and `s_axi_bresp` = `err_r` ? 2'b10 : 2'b00.
  - On `s_axi_bready`: clear `err_r` and go to IDLE.
- `err_r` is sticky across all lines of one request. It is cleared only by the B handshake or by reset.
- Only slots that were written carry nonzero strobes. Data in unwritten slots is 0.

## Timing
- Reset values, holding after the first `clk` edge with `rst`=1:
  - State is IDLE, so `cmd_rdy`=1.
  - `s_axi_wready`, `s_axi_bvalid`, `line_val`, `busy` and `err_r` are 0.
  - `cache_line`, `cache_line_strb` and `line_last` are 0.
  - `s_axi_bresp` and `s_axi_bid` are 0.
- Reset mid-operation discards the partial line and any pending B response.
- Command accepted at cycle N: `s_axi_wready`=1 at N+1.
- Final beat accepted at cycle N: `line_val`=1 at N+1.
- Line handshake at cycle N: `s_axi_bvalid`=1 at N+1 if `last_r`, otherwise `cmd_rdy`=1 at N+1.
- `s_axi_wready` depends only on the state (no combinational path from `wvalid`). `cmd_rdy` is likewise state-only.
- W beats arriving outside COLLECT are not accepted (`wready`=0).
- Minimum per-line overhead is 2 cycles (IDLE plus EMIT). Throughput is one beat per cycle inside COLLECT.

## Configuration
- `SHIELD_WRITE_SLV_WLAST_CHECK_EN` defined:
  - On each W handshake, the expected `wlast` is `last_r && rem==1`.
  - Any mismatch with `s_axi_wlast` sets `err_r`, so the request completes with SLVERR (2'b10).
- Macro not defined:
  - `s_axi_wlast` is ignored, `err_r` stays 0, and `bresp` is always OKAY.

## Structure
- Shared package `shield_pkg` holds:
  - the state enum (IDLE/COLLECT/EMIT/RESP);
  - the response constants `AXI_RESP_OKAY`=2'b00 and `AXI_RESP_SLVERR`=2'b10.
- `shield_counter` is reused for `idx` and `rem`, with `load` = command accept and `incr`/`decr` = W handshake.
- `shield_enreg` is reused for `last_r`.
- One new sub-module, `shield_demuxp`, is the write-side inverse of the line mux. It writes a `CL_DATA_WIDTH` slice and its strobe slice into slot `sel` of the line and strobe registers, with enable and clear inputs.

## Test plan
- Full line, single request:
  - Stimulus: offset 0, count 8, last=1; beats 0x0..0x7 with wstrb=0xFF; `wlast` on beat 7.
  - Response: `cache_line` slot k = k, strobe all 1s, `line_last`=1, then `bvalid` with `bresp`=0.
- Partial line:
  - Stimulus: offset 0x18, count 3, last=1.
  - Response: slots 3..5 written, strobe bits 24..47 set and all others 0.
- Two-line request:
  - Stimulus: line 1 with last=0, count 8; line 2 with last=1, count 8.
  - Response: no `bvalid` after line 1; exactly one `bvalid` after line 2.
- Backpressure:
  - Stimulus: hold `line_rdy`=0 for 5 cycles, then hold `bready`=0 for 3 cycles.
  - Response: outputs stay stable, `wready`=0 throughout, and exactly one handshake occurs on each channel.
- wlast check, macro defined:
  - Stimulus: count 4, last=1, `wlast` asserted on beat 2.
  - Response: `bresp`=2'b10. The next request responds 2'b00.
- Reset mid-operation:
  - Stimulus: assert `rst` after 3 of 8 beats.
  - Response: next cycle, state IDLE, `cmd_rdy`=1, `cache_line`=0; a fresh request completes normally.
